// File: rtl/mac_accumulator.sv
// Saturating multiply-accumulate stage: sums a programmed number of unsigned
// products from a valid/ready stream and returns the total on a second handshake.
module mac_accumulator #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 11,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              p_valid,
  input  logic [PROD_W-1:0] p_data,
  output logic              p_ready,
  output logic              acc_valid,
  output logic [ACC_W-1:0]  acc_data,
  input  logic              acc_ready,
  output logic              ovf,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W:0]     sum_sat;
  logic [CNT_W-1:0]   cnt_inc;

  // Returns {carry, result}; on carry-out the result is clamped to full scale.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0]  a,
                                             input logic [PROD_W-1:0] p);
    logic [ACC_W:0] sum;
    sum = {1'b0, a} + {{(ACC_W+1-PROD_W){1'b0}}, p};
    if (sum[ACC_W]) sat_add = {1'b1, {ACC_W{1'b1}}};
    else            sat_add = sum;
  endfunction

  assign sum_sat = sat_add(acc_q, p_data);
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
          if (len != '0) begin
            len_d   = len;
            state_d = ACCUM;
          end else begin
            state_d = DONE;
          end
        end
      end
      ACCUM: begin
        if (p_valid) begin
          acc_d = sum_sat[ACC_W-1:0];
          cnt_d = cnt_inc;
          if (sum_sat[ACC_W]) ovf_d = 1'b1;
          if (cnt_inc == len_q) state_d = DONE;
        end
      end
      DONE: begin
        if (acc_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake outputs depend on registered state only.
  assign p_ready   = (state_q == ACCUM);
  assign acc_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign acc_data  = acc_q;
  assign ovf       = ovf_q;

endmodule
